// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, sticky overflow/underflow errors and selectable first-word-fall-through read mode.
module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AFULL_LVL  = 6,
    parameter int unsigned AEMPTY_LVL = 1,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empt,
    output logic                  afull,
    output logic                  aempt,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = PW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_CNT  = PW'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = PW'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = PW'(1);

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 10) begin : g_bad_addr_width
        $error("fifo_sync_param: ADDR_WIDTH out of range 1..10");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_LVL out of range 1..DEPTH");
    end
    if (AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_LVL out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empt_q, empt_d;
    logic                  afull_q, afull_d;
    logic                  aempt_q, aempt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd & ~empt_q;
    assign wr_acc = wr & (~full_q | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (count_d == DEPTH_CNT);
        empt_d  = (count_d == '0);
        afull_d = (count_d >= AFULL_CNT);
        aempt_d = (count_d <= AEMPTY_CNT);
    end

    // A fresh error in the clearing cycle takes priority over clr_err.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (rd && !rd_acc) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empt_q   <= 1'b1;
            afull_q  <= 1'b0;
            aempt_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empt_q   <= empt_d;
            afull_q  <= afull_d;
            aempt_q  <= aempt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_idx] <= data_in;
        end
    end

    if (FWFT == 0) begin : g_std_read
        logic [DATA_WIDTH-1:0] data_out_q;
        logic                  rd_valid_q;

        // On pass-through the read samples the old word before the write lands.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_out_q <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    data_out_q <= mem[rd_idx];
                end
            end
        end

        assign data_out = data_out_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        assign data_out = empt_q ? '0 : mem[rd_idx];
        assign rd_valid = ~empt_q;
    end

    assign full  = full_q;
    assign empt  = empt_q;
    assign afull = afull_q;
    assign aempt = aempt_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-read instance and an FWFT instance, 8 deep.
module tb_fifo_sync_param;

    logic        clk;
    logic        rst;
    logic        wr, rd, clr_err;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rd_valid, full, empt, afull, aempt, ovf, udf;
    logic [3:0]  count;

    logic        f_rst;
    logic        f_wr, f_rd, f_clr_err;
    logic [31:0] f_data_in;
    logic [31:0] f_data_out;
    logic        f_rd_valid, f_full, f_empt, f_afull, f_aempt, f_ovf, f_udf;
    logic [3:0]  f_count;

    int n_cmp = 0;
    int n_err = 0;

    fifo_sync_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(3), .AFULL_LVL(6), .AEMPTY_LVL(1), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in), .clr_err(clr_err),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empt(empt), .afull(afull),
        .aempt(aempt), .count(count), .ovf(ovf), .udf(udf)
    );

    fifo_sync_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(3), .AFULL_LVL(6), .AEMPTY_LVL(1), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst(f_rst), .wr(f_wr), .rd(f_rd), .data_in(f_data_in),
        .clr_err(f_clr_err), .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full),
        .empt(f_empt), .afull(f_afull), .aempt(f_aempt), .count(f_count), .ovf(f_ovf),
        .udf(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_w;
        int          wcnt;
        int          n;

        rst = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
        f_rst = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_clr_err = 1'b0; f_data_in = '0;
        #12;
        rst = 1'b1; f_rst = 1'b1;
        step();

        // Reset then idle
        check_eq("rst_empt", 32'(empt), 32'd1);
        check_eq("rst_aempt", 32'(aempt), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_afull", 32'(afull), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_dout", data_out, 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_udf", 32'(udf), 32'd0);
        check_eq("rst_rdv", 32'(rd_valid), 32'd0);

        // Fill 1..8, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            wr = 1'b1; data_in = 32'(i);
            step();
            check_eq($sformatf("fill_count%0d", i), 32'(count), 32'(i));
            check_eq($sformatf("fill_afull%0d", i), 32'(afull), 32'(i >= 6));
            check_eq($sformatf("fill_full%0d", i), 32'(full), 32'(i == 8));
            check_eq($sformatf("fill_aempt%0d", i), 32'(aempt), 32'(i <= 1));
        end
        data_in = 32'h9;
        step();
        check_eq("ovf_set", 32'(ovf), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd8);
        wr = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            rd = 1'b1;
            step();
            check_eq($sformatf("drain_dout%0d", i), data_out, 32'(i));
            check_eq($sformatf("drain_rdv%0d", i), 32'(rd_valid), 32'd1);
            check_eq($sformatf("drain_count%0d", i), 32'(count), 32'(8 - i));
        end
        rd = 1'b0;
        check_eq("drain_empt", 32'(empt), 32'd1);
        step();
        check_eq("idle_rdv", 32'(rd_valid), 32'd0);
        check_eq("idle_dout_hold", data_out, 32'd8);
        check_eq("ovf_sticky", 32'(ovf), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_eq("ovf_clr", 32'(ovf), 32'd0);

        // Full pass-through
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; data_in = 32'hA0 + 32'(i);
            step();
        end
        check_eq("pt_full_pre", 32'(full), 32'd1);
        wr = 1'b1; rd = 1'b1; data_in = 32'hB0;
        step();
        check_eq("pt_count", 32'(count), 32'd8);
        check_eq("pt_dout", data_out, 32'hA0);
        check_eq("pt_ovf", 32'(ovf), 32'd0);
        wr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            exp_w = (i == 8) ? 32'hB0 : 32'hA0 + 32'(i);
            step();
            check_eq($sformatf("pt_drain%0d", i), data_out, exp_w);
        end
        rd = 1'b0;
        check_eq("pt_empt", 32'(empt), 32'd1);

        // Read on empty with simultaneous write
        wr = 1'b1; rd = 1'b1; data_in = 32'h55;
        step();
        check_eq("ue_udf", 32'(udf), 32'd1);
        check_eq("ue_count", 32'(count), 32'd1);
        check_eq("ue_ovf", 32'(ovf), 32'd0);
        wr = 1'b0;
        step();
        check_eq("ue_dout", data_out, 32'h55);
        check_eq("ue_count0", 32'(count), 32'd0);
        clr_err = 1'b1;
        step();
        check_eq("clr_vs_new_err", 32'(udf), 32'd1);
        rd = 1'b0;
        step();
        clr_err = 1'b0;
        check_eq("udf_clr", 32'(udf), 32'd0);

        // Wrap-around: 20 words in bursts of up to 3
        wcnt = 0;
        while (wcnt < 20) begin
            n = (20 - wcnt >= 3) ? 3 : 20 - wcnt;
            for (int k = 0; k < n; k++) begin
                wr = 1'b1; data_in = 32'hC00 + 32'(wcnt);
                q.push_back(data_in);
                wcnt++;
                step();
                check_eq("wrap_full", 32'(full), 32'd0);
            end
            wr = 1'b0;
            check_eq("wrap_count_hi", 32'(count), 32'(n));
            for (int k = 0; k < n; k++) begin
                rd = 1'b1;
                step();
                check_eq("wrap_data", data_out, q.pop_front());
            end
            rd = 1'b0;
            check_eq("wrap_empt", 32'(empt), 32'd1);
        end

        // FWFT instance
        f_wr = 1'b1; f_data_in = 32'h77;
        step();
        f_wr = 1'b0;
        check_eq("fw_empt", 32'(f_empt), 32'd0);
        check_eq("fw_dout", f_data_out, 32'h77);
        check_eq("fw_rdv", 32'(f_rd_valid), 32'd1);
        f_rd = 1'b1;
        step();
        f_rd = 1'b0;
        check_eq("fw_pop_empt", 32'(f_empt), 32'd1);
        check_eq("fw_pop_dout", f_data_out, 32'd0);
        check_eq("fw_pop_rdv", 32'(f_rd_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            f_wr = 1'b1; f_data_in = 32'hD0 + 32'(i);
            step();
        end
        f_wr = 1'b0;
        check_eq("fw_fill_count", 32'(f_count), 32'd5);
        check_eq("fw_fill_dout", f_data_out, 32'hD0);
        #2;
        f_rst = 1'b0;
        #1;
        check_eq("fw_arst_count", 32'(f_count), 32'd0);
        check_eq("fw_arst_empt", 32'(f_empt), 32'd1);
        check_eq("fw_arst_dout", f_data_out, 32'd0);
        #1;
        f_rst = 1'b1;
        step();
        check_eq("fw_post_empt", 32'(f_empt), 32'd1);
        f_wr = 1'b1; f_data_in = 32'hE1;
        step();
        f_wr = 1'b0;
        check_eq("fw_post_dout", f_data_out, 32'hE1);
        check_eq("fw_post_count", 32'(f_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 8-deep, 32-bit single-clock FIFO.
- Adds:
  - configurable width and depth
  - occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - selectable first-word-fall-through (FWFT) read mode
  - read-while-full pass-through
- Sits between bus-side producers and consumers in the datapath, as the drop-in buffer for DATA_BUS_SIZE-wide traffic.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 1..10.
- AFULL_LVL, 6, afull asserts when count >= AFULL_LVL; legal range 1..DEPTH.
- AEMPTY_LVL, 1, aempt asserts when count <= AEMPTY_LVL; legal range 0..DEPTH-1.
- FWFT, 0; 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- wr  input  1  write request.
- rd  input  1  read request / pop.
- data_in  input  DATA_WIDTH  write data.
- clr_err  input  1  synchronous clear of ovf and udf.
- data_out  output  DATA_WIDTH  read data.
- rd_valid  output  1  standard mode: data_out updated this cycle. FWFT mode: equals !empt.
- full  output  1  count == DEPTH.
- empt  output  1  count == 0.
- afull  output  1  count >= AFULL_LVL.
- aempt  output  1  count <= AEMPTY_LVL.
- count  output  ADDR_WIDTH+1  words stored, 0..DEPTH.
- ovf  output  1  sticky: a write was rejected.
- udf  output  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers, count and data_out go to 0.
  - rd_valid, ovf and udf go to 0.
  - empt=1, aempt=1, full=0, afull=0 (AFULL_LVL>=1).
  - Memory array is not reset. Reset mid-operation discards all contents; the first cycle after release behaves as empty.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the extra MSB is the wrap bit. Lower bits index memory.
  - Each pointer increments by 1 modulo 2**(ADDR_WIDTH+1).
  - count = wr_ptr - rd_ptr, in ADDR_WIDTH+1-bit arithmetic.
- Flags:
  - full, empt, afull, aempt and count are registered.
  - They reflect state after the last clock edge and update in the same cycle as the pointers.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd & !empt.
  - wr_acc = wr & (!full | rd_acc); a write to a full FIFO is accepted when a read is accepted in the same cycle.
- Simultaneous access:
  - rd_acc & wr_acc: count unchanged; both pointers advance.
  - rd & wr while empty: write accepted, read rejected, udf sets.
  - Same-address write/read never occurs except in the full-pass-through case. There the read returns the old word, and the new word lands in the freed slot.
- Errors:
  - wr & !wr_acc sets ovf; rd & !rd_acc sets udf.
  - Both flags hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the new error wins (flag stays 1).
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at the edge; latency is 1 cycle.
  - rd_valid is 1 for exactly the cycle after rd_acc.
  - data_out holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally when !empt, and 0 when empt.
  - rd acts as a pop.
  - A word written into an empty FIFO appears on data_out 1 cycle after the write edge, when empt falls.
- Memory write: on wr_acc, mem[wr_ptr] <= data_in.

Test Plan:
- Reset then idle (DEPTH=8) -> empt=1, aempt=1, full=0, afull=0, count=0, data_out=0, ovf=0, udf=0.
- Write 0x1..0x8 on 8 consecutive cycles, then 1 extra write of 0x9:
  - count steps 1..8.
  - afull rises when count=6, full rises at count=8.
  - The extra write sets ovf=1 and leaves count=8.
  - Then read 8 cycles (FWFT=0): data_out=0x1..0x8 each 1 cycle after rd, with rd_valid high; empt=1 after the 8th read.
- Full pass-through: fill with 0xA0..0xA7, then rd=wr=1 with data_in=0xB0:
  - count stays 8 and data_out=0xA0.
  - Draining 8 more reads returns 0xA1..0xA7 then 0xB0.
- Read on empty with rd=wr=1, data_in=0x55:
  - udf=1 and count=1.
  - A following rd returns 0x55.
  - clr_err=1 for 1 cycle clears udf only when no new error occurs in that cycle.
- Wrap-around: 20 write/read pairs with count oscillating 0..3 -> data order preserved across the pointer wrap bit; full never asserts.
- FWFT=1: write 0x77 to empty -> next cycle empt=0, data_out=0x77, rd_valid=1. Then rd=1 -> empt=1 and data_out=0. Assert rst=0 mid-fill at count=5 -> count=0 and empt=1 immediately, without waiting for a clock edge.
